fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one 8-deep byte FIFO write port between NUM_REQ producers.
- Grants one producer at a time for a bounded burst and drives the FIFO write/enable/data inputs.
- Back-pressures every producer from the FIFO full flag.
- Sits between the producer blocks and the FIFO; the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, data width; matches the FIFO data_in width.
- MAX_BURST, 4, maximum beats per grant (1..16).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester beat valid; held until gnt.
- req_data  input  NUM_REQ*DATA_W  packed data; requester i uses bits [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  marks the final beat of a requester's burst.
- gnt  output  NUM_REQ  one-hot beat-accept strobe; combinational.
- fifo_full  input  1  FIFO full flag.
- fifo_enable  output  1  FIFO enable; registered.
- fifo_write  output  1  FIFO write strobe; combinational, equals OR of gnt.
- fifo_data  output  DATA_W  data of the accepted beat; combinational mux.
- busy  output  1  high while in BURST.
- owner  output  3  index of the current/last owner.
- beat_cnt_o  output  4  beats taken in the current burst.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, last_owner = NUM_REQ-1 (so req[0] wins first), beat_cnt = 0, fifo_enable = 0.
  - gnt = 0, fifo_write = 0, fifo_data = 0, busy = 0, owner = NUM_REQ-1.
- fifo_enable goes 1 on the first posedge after rst deasserts and stays 1.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req bit is set, select the first set bit scanning from last_owner+1 upward, wrapping mod NUM_REQ.
  - Register that index as owner, clear beat_cnt, go to BURST.
  - No beat is accepted in IDLE, so there is one bubble cycle per arbitration.
- BURST beat rule:
  - gnt[owner] = req[owner] and not fifo_full and fifo_enable.
  - All other gnt bits are 0.
  - fifo_write = gnt[owner]; fifo_data = req_data slice of owner when fifo_write=1, else 0.
  - The FIFO captures the beat on the same posedge (zero latency).
- BURST advance: on a beat, beat_cnt increments.
- Leave BURST to IDLE at the posedge where any of these holds:
  - a) beat accepted with req_last[owner] = 1;
  - b) beat accepted with beat_cnt = MAX_BURST-1;
  - c) req[owner] = 0, i.e. the burst is abandoned and no beat occurs that cycle.
  - On exit, last_owner = owner and beat_cnt clears.
- fifo_full while in BURST:
  - Hold state, no gnt, beat_cnt frozen, owner kept.
  - No preemption; other requesters wait.
- Fairness: a requester continuously asserting req is granted at least once every NUM_REQ bursts.
- req_last on a non-accepted cycle has no effect.
- MAX_BURST = 1: every beat ends the burst; the arbiter alternates IDLE/BURST.
- Changing req_data while gnt = 0 is legal; only the granted cycle's value is written.
- Reset mid-burst: the beat in that cycle is dropped (gnt forced low at once), and round-robin restarts at req[0].
- beat_cnt width is 4 bits; it never exceeds MAX_BURST-1.

Test Plan:
- Reset then req=0001 with last on the 3rd beat, FIFO empty → one IDLE cycle, gnt[0] for 3 consecutive cycles, fifo_data = 0x11,0x22,0x33, then IDLE, owner=0.
- req=1111 held, never last, MAX_BURST=4 → grant order 0,1,2,3,0, 4 beats each, one idle cycle between bursts, 20 writes total in 25 cycles.
- Owner 1 bursting, fifo_full asserted for 5 cycles mid-burst → gnt=0 and fifo_write=0 for those 5 cycles, beat_cnt frozen at 2, owner stays 1, burst resumes and finishes its remaining 2 beats.
- Owner 2 drops req after 1 beat without last → returns to IDLE next edge, last_owner=2, next grant goes to 3 if requesting, else 0.
- rst pulsed asynchronously mid-cycle during a BURST beat → gnt and fifo_write fall before the next edge, fifo_enable=0, first grant after release goes to req[0].
- Only req[3] active, MAX_BURST=2, 6 beats with no last → three bursts of 2 beats, each separated by one idle cycle, owner=3 throughout.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle for the round-robin FIFO write arbiter.
// req_data lane i occupies bits [i*DATA_W +: DATA_W] of the packed vector.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             gnt;
    logic                           fifo_full;
    logic                           fifo_enable;
    logic                           fifo_write;
    logic [DATA_W-1:0]              fifo_data;
    logic                           busy;
    logic [2:0]                     owner;
    logic [3:0]                     beat_cnt_o;

    modport master (
        output req, req_data, req_last, fifo_full,
        input  gnt, fifo_enable, fifo_write, fifo_data, busy, owner, beat_cnt_o
    );
    modport slave (
        input  req, req_data, req_last, fifo_full,
        output gnt, fifo_enable, fifo_write, fifo_data, busy, owner, beat_cnt_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.
// Lane cells gate each producer's grant and data; the FSM owns selection and burst length.
module fifo_wr_arbiter_lane #(
    parameter int DATA_W = 8
) (
    input  logic              sel,
    input  logic              req,
    input  logic              ok,
    input  logic [DATA_W-1:0] data,
    output logic              gnt,
    output logic [DATA_W-1:0] data_m
);
    assign gnt    = sel & req & ok;
    assign data_m = gnt ? data : '0;
endmodule

module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t                         state, state_nxt;
    logic [2:0]                     owner_q, owner_nxt, pick;
    logic [3:0]                     cnt_q, cnt_nxt;
    logic                           en_q;
    logic [NUM_REQ-1:0]             own_oh, gnt_l;
    logic [NUM_REQ-1:0][DATA_W-1:0] data_m;
    logic                           beat_ok, beat, req_own, last_own;

    // owner_q doubles as last_owner while IDLE, so the scan starts right after it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner_q <= 3'(NUM_REQ-1);
            cnt_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner_q <= owner_nxt;
            cnt_q   <= cnt_nxt;
            en_q    <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) own_oh[i] = (owner_q == 3'(i));
    end

    assign beat_ok  = (state == BURST) && !bus.fifo_full && en_q;
    assign beat     = |gnt_l;
    assign req_own  = |(bus.req & own_oh);
    assign last_own = |(bus.req_last & own_oh);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        fifo_wr_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
            .sel    (own_oh[i]),
            .req    (bus.req[i]),
            .ok     (beat_ok),
            .data   (bus.req_data[i]),
            .gnt    (gnt_l[i]),
            .data_m (data_m[i])
        );
    end

    always_comb begin
        int idx;
        logic found;
        pick  = owner_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(owner_q) + k) % NUM_REQ;
            if (!found && bus.req[idx]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
    end

    // Abandonment (owner drops req) ends the burst even while the FIFO is full
    always_comb begin
        state_nxt = state;
        owner_nxt = owner_q;
        cnt_nxt   = cnt_q;
        case (state)
            IDLE: if (|bus.req) begin
                owner_nxt = pick;
                cnt_nxt   = '0;
                state_nxt = BURST;
            end
            BURST: begin
                if (beat) begin
                    if (last_own || cnt_q == 4'(MAX_BURST-1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + 4'd1;
                    end
                end else if (!req_own) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state == BURST);
        bus.gnt         = gnt_l;
        bus.fifo_write  = beat;
        bus.fifo_enable = en_q;
        bus.owner       = owner_q;
        bus.beat_cnt_o  = cnt_q;
        bus.fifo_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) bus.fifo_data = bus.fifo_data | data_m[i];
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random producers, all cycles
// checked against a priority-queue model of the round-robin burst rules.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic clk, rst;
    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) ifc ();

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: priority order held as a queue, rotated so the last owner sits at the back
    int q_prio[$];
    bit m_en, m_busy;
    int m_own, m_cnt;

    task automatic m_reset();
        q_prio.delete();
        for (int i = 0; i < NUM_REQ; i++) q_prio.push_back(i);
        m_own = NUM_REQ-1; m_busy = 0; m_cnt = 0; m_en = 0;
    endtask

    task automatic m_end_burst();
        m_busy = 0; m_cnt = 0;
        while (q_prio[$] != m_own) q_prio.push_back(q_prio.pop_front());
    endtask

    logic [NUM_REQ-1:0] s_gnt;
    logic               s_wr, s_busy, s_en;
    logic [DATA_W-1:0]  s_data;
    logic [2:0]         s_own;
    logic [3:0]         s_cnt;

    // Called at a negedge with inputs already driven; returns at the next negedge
    task automatic cycle();
        logic [NUM_REQ-1:0] e_gnt;
        logic [DATA_W-1:0]  e_data;
        #1;
        e_gnt = '0;
        if (m_busy && m_en && ifc.req[m_own] && !ifc.fifo_full) e_gnt[m_own] = 1'b1;
        e_data = (e_gnt != 0) ? ifc.req_data[m_own] : '0;
        s_gnt = ifc.gnt; s_wr = ifc.fifo_write; s_data = ifc.fifo_data;
        s_busy = ifc.busy; s_own = ifc.owner; s_cnt = ifc.beat_cnt_o; s_en = ifc.fifo_enable;
        chk("gnt", 32'(s_gnt), 32'(e_gnt));
        chk("fifo_write", 32'(s_wr), 32'(e_gnt != 0));
        chk("fifo_data", 32'(s_data), 32'(e_data));
        chk("busy", 32'(s_busy), 32'(m_busy));
        chk("owner", 32'(s_own), 32'(m_own));
        chk("beat_cnt", 32'(s_cnt), 32'(m_cnt));
        chk("fifo_enable", 32'(s_en), 32'(m_en));
        @(posedge clk);
        if (!m_busy) begin
            for (int k = 0; k < q_prio.size(); k++)
                if (ifc.req[q_prio[k]]) begin
                    m_own = q_prio[k]; m_busy = 1; m_cnt = 0;
                    break;
                end
        end else if (e_gnt != 0) begin
            m_cnt++;
            if (ifc.req_last[m_own] || m_cnt == MAX_BURST) m_end_burst();
        end else if (!ifc.req[m_own]) begin
            m_end_burst();
        end
        m_en = 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_reset();
        chk("rst_gnt", 32'(ifc.gnt), 0);
        chk("rst_write", 32'(ifc.fifo_write), 0);
        chk("rst_data", 32'(ifc.fifo_data), 0);
        chk("rst_busy", 32'(ifc.busy), 0);
        chk("rst_owner", 32'(ifc.owner), NUM_REQ-1);
        chk("rst_cnt", 32'(ifc.beat_cnt_o), 0);
        chk("rst_en", 32'(ifc.fifo_enable), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int nwr, ord, bad;
    int rem [NUM_REQ];

    initial begin
        ifc.req = '0; ifc.req_data = '0; ifc.req_last = '0; ifc.fifo_full = 1'b0;
        do_reset();

        // Single producer, last on third beat
        ifc.req = 4'b0001; ifc.req_data[0] = 8'h11;
        cycle(); chk("t1_bubble", 32'(s_wr), 0);
        for (int i = 0; i < 3; i++) begin
            ifc.req_data[0] = 8'((i+1)*17); ifc.req_last[0] = (i == 2);
            cycle();
            chk("t1_data", 32'(s_data), (i+1)*17);
            chk("t1_gnt", 32'(s_gnt), 1);
        end
        ifc.req = '0; ifc.req_last = '0;
        cycle(); chk("t1_idle", 32'(s_busy), 0); chk("t1_owner", 32'(s_own), 0);

        // All requesting, never last: bursts of MAX_BURST in order 0,1,2,3,0
        do_reset();
        ifc.req = 4'hf; nwr = 0; ord = 0;
        for (int c = 0; c < 25; c++) begin
            for (int i = 0; i < NUM_REQ; i++) ifc.req_data[i] = 8'($urandom);
            cycle();
            if (s_wr) nwr++;
            if (s_wr && s_cnt == 0) ord = ord*16 + int'(s_own);
        end
        chk("t2_writes", nwr, 20);
        chk("t2_order", ord, 32'h01230);

        // Owner 1 stalled by fifo_full mid-burst
        ifc.req = 4'b0010;
        cycle(); cycle(); cycle();
        ifc.fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("t3_gnt", 32'(s_gnt), 0); chk("t3_cnt", 32'(s_cnt), 2); chk("t3_own", 32'(s_own), 1);
        end
        ifc.fifo_full = 1'b0; nwr = 0;
        for (int c = 0; c < 2; c++) begin cycle(); if (s_wr) nwr++; end
        chk("t3_resume", nwr, 2);
        ifc.req = '0;
        cycle(); chk("t3_done", 32'(s_busy), 0);

        // Owner 2 abandons after one beat; owner 3 is next
        ifc.req = 4'b0100;
        cycle(); cycle(); chk("t4_beat", 32'(s_gnt), 4);
        ifc.req = '0;
        cycle(); chk("t4_abandon", 32'(s_wr), 0);
        ifc.req = 4'b1001;
        cycle(); chk("t4_idle", 32'(s_busy), 0); chk("t4_last", 32'(s_own), 2);
        cycle(); chk("t4_next", 32'(s_gnt), 8);
        ifc.req = '0;
        cycle(); cycle();

        // Asynchronous reset in the middle of a beat
        ifc.req = 4'b0001;
        cycle();
        #1 chk("t5_pre", 32'(ifc.gnt), 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_gnt", 32'(ifc.gnt), 0); chk("t5_write", 32'(ifc.fifo_write), 0);
        chk("t5_en", 32'(ifc.fifo_enable), 0); chk("t5_busy", 32'(ifc.busy), 0);
        m_reset();
        @(negedge clk);
        rst = 1'b0; ifc.req = 4'b0011;
        cycle(); cycle(); chk("t5_first", 32'(s_gnt), 1);
        ifc.req = '0;
        cycle(); cycle();

        // Lone requester 3 with no last: bursts capped at MAX_BURST
        ifc.req = 4'b1000; nwr = 0; bad = 0;
        for (int c = 0; c < 3*(MAX_BURST+1); c++) begin
            cycle();
            if (s_wr) nwr++;
            if (s_wr && s_own != 3) bad++;
        end
        chk("t6_writes", nwr, 3*MAX_BURST);
        chk("t6_owner", bad, 0);
        ifc.req = '0;
        cycle();

        // Random producers with stalls, data churn and occasional abandonment
        for (int i = 0; i < NUM_REQ; i++) rem[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            ifc.fifo_full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ifc.req[i]) begin
                    if (!ifc.fifo_full && $urandom_range(0, 19) == 0) begin
                        ifc.req[i] = 1'b0; rem[i] = 0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    ifc.req[i] = 1'b1; rem[i] = $urandom_range(1, 6);
                end
                ifc.req_data[i] = 8'($urandom);
                ifc.req_last[i] = ifc.req[i] ? (rem[i] == 1) : 1'($urandom);
            end
            cycle();
            for (int i = 0; i < NUM_REQ; i++)
                if (s_gnt[i]) begin
                    rem[i]--;
                    if (rem[i] <= 0) ifc.req[i] = 1'b0;
                end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
